// File: rtl/tinytpu_pkg.sv
// Shared types and derived sizes for the tinytpu sequencing controller.
package tinytpu_pkg;

    localparam int D_W_DEF   = 8;
    localparam int N_DEF     = 2;
    localparam int WORD_DEF  = 4;
    localparam int ACC_W_DEF = 18;
    localparam int CW_DEF    = 7;

    localparam int LOAD_BITS  = WORD_DEF * D_W_DEF;
    localparam int COMP_STEPS = 3 * N_DEF - 2;
    localparam int TX_BITS    = WORD_DEF * ACC_W_DEF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        CAPTURE = 3'd3,
        TX      = 3'd4
    } state_t;

endpackage

// File: rtl/tinytpu_ctrl_cnt.sv
// Shared phase counter: clears on request, counts on enable, wraps to 0 at a runtime limit.
module tinytpu_ctrl_cnt #(
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] limit,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] cnt_nxt,
    output logic          tc
);

    // Exact match keeps the count from ever passing its terminal value.
    assign tc = (cnt == limit);

    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (en) begin
            cnt_nxt = tc ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/tinytpu_ctrl.sv
// Sequencer for the serial-in/serial-out systolic datapath: LOAD -> COMPUTE -> CAPTURE -> TX.
// All outputs are registered decodes of the next state, so they line up with the state register.
module tinytpu_ctrl
    import tinytpu_pkg::*;
#(
    parameter int D_W   = 8,
    parameter int N     = 2,
    parameter int WORD  = 4,
    parameter int ACC_W = 18,
    parameter int CW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init,
    input  logic          load_en,
    output logic          buf_shift_en,
    output logic          arr_clr,
    output logic          arr_en,
    output logic [CW-1:0] step,
    output logic          res_capture,
    output logic          tx_shift_en,
    output logic          tx_ready,
    output logic          busy,
    output logic          done,
    output logic          overrun
);

    localparam logic [CW-1:0] LOAD_LAST = CW'(WORD * D_W - 1);
    localparam logic [CW-1:0] COMP_LAST = CW'(3 * N - 2 - 1);
    localparam logic [CW-1:0] TX_LAST   = CW'(WORD * ACC_W - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] limit;
    logic          tc;
    logic          cnt_clr;
    logic          cnt_en;
    logic          init_acc;
    logic          shift_nxt;
    logic          done_nxt;

    tinytpu_ctrl_cnt #(.CW(CW)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .limit   (limit),
        .cnt     (cnt),
        .cnt_nxt (cnt_nxt),
        .tc      (tc)
    );

    always_comb begin
        limit = '0;
        case (state)
            LOAD:    limit = LOAD_LAST;
            COMPUTE: limit = COMP_LAST;
            TX:      limit = TX_LAST;
            default: limit = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // init outranks everything else: from any busy state it restarts the load phase.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        init_acc  = 1'b0;
        shift_nxt = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (init) begin
                    state_nxt = LOAD;
                    cnt_clr   = 1'b1;
                    init_acc  = 1'b1;
                end
            end
            LOAD: begin
                if (init) begin
                    cnt_clr  = 1'b1;
                    init_acc = 1'b1;
                end else if (load_en) begin
                    cnt_en    = 1'b1;
                    shift_nxt = 1'b1;
                    if (tc) state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                if (init) begin
                    state_nxt = LOAD;
                    cnt_clr   = 1'b1;
                    init_acc  = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                    if (tc) state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                state_nxt = init ? LOAD : TX;
                cnt_clr   = 1'b1;
                init_acc  = init;
            end
            TX: begin
                if (init) begin
                    state_nxt = LOAD;
                    cnt_clr   = 1'b1;
                    init_acc  = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                    if (tc) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_clr   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_shift_en <= 1'b0;
            arr_clr      <= 1'b0;
            arr_en       <= 1'b0;
            step         <= '0;
            res_capture  <= 1'b0;
            tx_shift_en  <= 1'b0;
            tx_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            buf_shift_en <= shift_nxt;
            arr_clr      <= init_acc;
            arr_en       <= (state_nxt == COMPUTE);
            step         <= (state_nxt == COMPUTE) ? cnt_nxt : '0;
            res_capture  <= (state_nxt == CAPTURE);
            tx_shift_en  <= (state_nxt == TX);
            tx_ready     <= (state_nxt == TX);
            busy         <= (state_nxt != IDLE);
            done         <= done_nxt;
            // A fresh start from IDLE wins over a stray load_en in the same cycle.
            if (init && state == IDLE) begin
                overrun <= 1'b0;
            end else if (load_en && state != LOAD) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: doc/tinytpu_ctrl.md
Name: tinytpu_ctrl

Overview:
Sequencing controller for the tinytpu serial-in/serial-out systolic datapath. Accepts the pin-level init/load_en strobes and drives all datapath enables:
- operand shift-in
- array clear/enable and skew step index
- result capture
- serial transmit with tx_ready framing

Sits between the top-level pin mapping and tinytpu_top's buffers/array; contains no datapath storage.

Parameters:
- D_W, 8, operand element width in bits
- N, 2, systolic array dimension (N x N)
- WORD, 4, elements per operand matrix (must equal N*N)
- ACC_W, 18, result element width in bits shifted out per element
- CW, 7, shared counter width; must hold max(WORD*D_W, WORD*ACC_W, 3N-2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- init  in  1  start/abort strobe (level, sampled each clk)
- load_en  in  1  serial operand bit valid on x/y this cycle
- buf_shift_en  out  1  shift x/y operand buffers by one bit
- arr_clr  out  1  clear array accumulators (1-cycle pulse)
- arr_en  out  1  advance systolic array one step
- step  out  CW  current skew step index during COMPUTE, else 0
- res_capture  out  1  parallel-load result shift register (1-cycle pulse)
- tx_shift_en  out  1  shift result register, one bit out on data_out_z
- tx_ready  out  1  data_out_z carries a valid result bit this cycle
- busy  out  1  state != IDLE
- done  out  1  1-cycle pulse after last TX bit
- overrun  out  1  sticky: load_en seen while not in LOAD

Behaviour:
- Reset: state=IDLE, cnt=0, overrun=0. All outputs 0 while rst is high and in the cycle after release.
- All outputs are registered (Moore), so they are valid the cycle after the state/cnt update that causes them.
- IDLE:
  - init=1: pulse arr_clr, cnt<=0, go to LOAD.
  - load_en alone: ignored, sets overrun.
- LOAD:
  - load_en=1: buf_shift_en=1, cnt++.
  - load_en=0: stall; cnt holds, no shift.
  - On the accepted bit with cnt==WORD*D_W-1 (31): cnt<=0, go to COMPUTE.
  - init=1: restart. arr_clr pulse, cnt<=0, that cycle's load_en bit is NOT shifted. init has priority over load_en.
- COMPUTE:
  - arr_en=1, step=cnt, for exactly 3N-2 cycles (4 at defaults).
  - After the last step go to CAPTURE.
- CAPTURE: res_capture=1 for one cycle, cnt<=0, go to TX.
- TX:
  - tx_shift_en=1 and tx_ready=1 for exactly WORD*ACC_W cycles (72 at defaults), contiguous, no backpressure.
  - On the last bit go to IDLE and pulse done in the next cycle.
- init in COMPUTE/CAPTURE/TX: abort. tx_ready drops the next cycle, arr_clr pulses, cnt<=0, go to LOAD, no done pulse.
- load_en outside LOAD: no shift, overrun<=1.
- overrun clears only on rst or on an init accepted from IDLE.
- One shared counter cnt:
  - wraps to 0 on every state change
  - never exceeds its terminal value
  - terminal comparisons are exact (==), not >=
- Mid-operation asynchronous rst: immediate return to IDLE, all outputs 0; no partial done.
- Illegal state encodings recover to IDLE.

Decomposition:
- Package tinytpu_pkg holds:
  - state enum (IDLE, LOAD, COMPUTE, CAPTURE, TX)
  - localparams LOAD_BITS=WORD*D_W, COMP_STEPS=3*N-2, TX_BITS=WORD*ACC_W
- One natural sub-module: tinytpu_ctrl_cnt (loadable up-counter with clear, enable, and terminal-count flag for a runtime-selected limit).
- FSM and output registers stay in tinytpu_ctrl.

Test Plan:
- Reset: hold rst 3 cycles with init=1 and load_en=1 -> all outputs 0, busy=0; release -> still IDLE, overrun=0.
- Nominal: init 1 cycle, then 32 consecutive load_en cycles -> 32 buf_shift_en pulses; arr_en high 4 cycles with step 0,1,2,3; one res_capture; tx_ready high exactly 72 contiguous cycles; done pulses once; busy falls with done.
- Stalled load: load_en toggles 1,0 for 64 cycles -> exactly 32 shifts, COMPUTE entered only after the 32nd accepted bit.
- Restart in LOAD: after 10 accepted bits assert init together with load_en -> no shift that cycle, arr_clr pulse, then 32 further bits required before COMPUTE.
- Abort in TX: init at TX bit 20 -> tx_ready low next cycle, arr_clr pulse, state LOAD, no done.
- Overrun: load_en=1 for 1 cycle during COMPUTE -> overrun=1, array sequence unaffected (still 4 steps, 72 TX bits); next init from IDLE clears overrun.
